// File: rtl/nvram_pkg.sv
// Shared definitions for the NVRAM store/recall sequencer.
package nvram_pkg;

    localparam int ADDR_W_DEF        = 8;
    localparam int STORE_CYCLES_DEF  = 512;
    localparam int RECALL_CYCLES_DEF = 2;

    typedef enum logic [2:0] {
        ST_PWRUP      = 3'd0,
        ST_IDLE       = 3'd1,
        ST_STORE      = 3'd2,
        ST_RECALL     = 3'd3,
        ST_HPS        = 3'd4,
        ST_HPS_COMMIT = 3'd5
    } nvram_state_e;

    // Busy counter width; never narrower than one bit.
    function automatic int cnt_width(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/nvram_edge_latch.sv
// Edge detector plus pending flag for one request line.
// req_o is high from the cycle the edge is seen until the request is serviced
// (clr_i). Reset re-primes the previous-value register with the current input
// so a line already asserted at reset does not produce a phantom edge.
module nvram_edge_latch (
    input  logic clk,
    input  logic reset_n,
    input  logic sig_i,
    input  logic clr_i,
    output logic req_o
);

    logic prev_q;
    logic pend_q;
    logic pend_d;
    logic edge_det;

    assign edge_det = sig_i & ~prev_q;
    assign req_o    = pend_q | edge_det;

    // Pending flag: set by an edge, held until the sequencer services it.
    always_comb begin
        pend_d = (pend_q | edge_det) & ~clr_i;
    end

    // Previous-value and pending registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prev_q <= sig_i;
            pend_q <= 1'b0;
        end else begin
            prev_q <= sig_i;
            pend_q <= pend_d;
        end
    end

endmodule

// File: rtl/nvram_sequencer.sv
// Sequences power-up recall, STORE/RECALL requests and power-fail stores for
// an X2212-style NVRAM, and arbitrates the array between the CPU bus and the
// HPS save/load port.
module nvram_sequencer
    import nvram_pkg::*;
#(
    parameter int ADDR_W        = ADDR_W_DEF,
    parameter int STORE_CYCLES  = STORE_CYCLES_DEF,
    parameter int RECALL_CYCLES = RECALL_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ce2Hd,
    input  logic              cpu_sel_n,
    input  logic              cpu_rw_n,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_din,
    input  logic              store_req,
    input  logic              recall_req_n,
    input  logic              dcok_n,
    input  logic              hps_req,
    input  logic              hps_wr,
    input  logic [ADDR_W-1:0] hps_addr,
    input  logic [7:0]        hps_din,
    output logic              hps_gnt,
    output logic              nv_store,
    output logic              nv_recall,
    output logic              nv_we,
    output logic [ADDR_W-1:0] nv_addr,
    output logic [7:0]        nv_din,
    output logic              busy
);

    localparam int               CNT_W       = cnt_width(STORE_CYCLES);
    localparam logic [CNT_W-1:0] STORE_LOAD  = CNT_W'(STORE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RECALL_LOAD = CNT_W'(RECALL_CYCLES - 1);

    nvram_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pw_init_q, pw_init_d;
    logic             wrote_q, wrote_d;
    logic             store_pulse_q, store_pulse_d;
    logic             recall_pulse_q, recall_pulse_d;

    logic pf_req, st_req, rc_req;
    logic pf_clr, st_clr, rc_clr;
    logic storing;

    // Power-fail: DCOKn rising. Store: level rising. Recall: active-low falling.
    nvram_edge_latch u_pf_latch (
        .clk     (clk),
        .reset_n (reset_n),
        .sig_i   (dcok_n),
        .clr_i   (pf_clr),
        .req_o   (pf_req)
    );

    nvram_edge_latch u_store_latch (
        .clk     (clk),
        .reset_n (reset_n),
        .sig_i   (store_req),
        .clr_i   (st_clr),
        .req_o   (st_req)
    );

    nvram_edge_latch u_recall_latch (
        .clk     (clk),
        .reset_n (reset_n),
        .sig_i   (~recall_req_n),
        .clr_i   (rc_clr),
        .req_o   (rc_req)
    );

    assign storing = (state_q == ST_STORE) || (state_q == ST_HPS_COMMIT);

    // Next-state, counter and pulse logic. Store/power-fail requests arriving
    // while a store is already running are consumed (dropped) here.
    always_comb begin
        state_d        = state_q;
        cnt_d          = (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
        pw_init_d      = pw_init_q;
        wrote_d        = 1'b0;
        store_pulse_d  = 1'b0;
        recall_pulse_d = 1'b0;
        pf_clr         = storing;
        st_clr         = storing;
        rc_clr         = 1'b0;

        case (state_q)
            ST_PWRUP: begin
                if (pw_init_q) begin
                    pw_init_d      = 1'b0;
                    recall_pulse_d = 1'b1;
                    cnt_d          = RECALL_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end
            end

            ST_IDLE: begin
                if (pf_req || st_req) begin
                    state_d       = ST_STORE;
                    cnt_d         = STORE_LOAD;
                    store_pulse_d = 1'b1;
                    pf_clr        = 1'b1;
                    st_clr        = 1'b1;
                end else if (rc_req) begin
                    state_d        = ST_RECALL;
                    cnt_d          = RECALL_LOAD;
                    recall_pulse_d = 1'b1;
                    rc_clr         = 1'b1;
                end else if (hps_req) begin
                    state_d = ST_HPS;
                end
            end

            ST_STORE, ST_HPS_COMMIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end
            end

            ST_RECALL: begin
                if (pf_req) begin
                    state_d       = ST_STORE;
                    cnt_d         = STORE_LOAD;
                    store_pulse_d = 1'b1;
                    pf_clr        = 1'b1;
                    st_clr        = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end
            end

            ST_HPS: begin
                wrote_d = wrote_q | (hps_wr & hps_req);
                if (pf_req) begin
                    state_d       = ST_STORE;
                    cnt_d         = STORE_LOAD;
                    store_pulse_d = 1'b1;
                    pf_clr        = 1'b1;
                    st_clr        = 1'b1;
                end else if (!hps_req) begin
                    if (wrote_q) begin
                        state_d       = ST_HPS_COMMIT;
                        cnt_d         = STORE_LOAD;
                        store_pulse_d = 1'b1;
                        st_clr        = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d   = ST_PWRUP;
                pw_init_d = 1'b1;
                cnt_d     = '0;
            end
        endcase
    end

    // State, counter and pulse registers; reset restarts the power-up recall.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= ST_PWRUP;
            cnt_q          <= '0;
            pw_init_q      <= 1'b1;
            wrote_q        <= 1'b0;
            store_pulse_q  <= 1'b0;
            recall_pulse_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            pw_init_q      <= pw_init_d;
            wrote_q        <= wrote_d;
            store_pulse_q  <= store_pulse_d;
            recall_pulse_q <= recall_pulse_d;
        end
    end

    // Array-side outputs. The grant drops in the same cycle hps_req goes low.
    always_comb begin
        hps_gnt   = (state_q == ST_HPS) & hps_req;
        nv_store  = store_pulse_q;
        nv_recall = recall_pulse_q;
        busy      = (state_q == ST_PWRUP) || (state_q == ST_RECALL) || storing;
        nv_we     = 1'b0;
        nv_addr   = cpu_addr;
        nv_din    = cpu_din;
        if (state_q == ST_IDLE) begin
            nv_we = ~cpu_sel_n & ~cpu_rw_n & ce2Hd;
        end else if (state_q == ST_HPS) begin
            nv_we   = hps_gnt & hps_wr;
            nv_addr = hps_addr;
            nv_din  = hps_din;
        end
    end

endmodule
